// File: rtl/fp_norm_pipe.sv
// fp_norm_pipe: two-stage pipelined leading-one normaliser for the FP multiplier datapath.
// Latency 2 cycles from accept to out_valid; 1 transaction/cycle; holds at most 2 in flight.
// Backpressure: out_ready=0 freezes stage 2 and then stage 1; in_ready drops when both are full.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_mant (MANT_W) and in_exp (EXP_W) sampled on accept
//   out_valid/out_ready   output handshake
//   out_mant, out_exp     normalised mantissa and adjusted biased exponent
//   out_shift (SH_W)      left shift actually applied
//   out_zero, out_denorm  input mantissa was zero / result is subnormal (exponent clamped to 0)
//
// Build option: define FP_NORM_FLUSH_EN to flush every underflowing result to zero
// (out_zero=1, out_denorm=1, data 0). Default build produces gradual subnormals.

module fp_norm_pipe #(
    parameter  int MANT_W = 24,
    parameter  int EXP_W  = 8,
    localparam int SH_W   = $clog2(MANT_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic [SH_W-1:0]   out_shift,
    output logic              out_zero,
    output logic              out_denorm
);

    // Compare width: wide enough for both the exponent plus a borrow bit and the lzc.
    localparam int CW = ((EXP_W + 1) > SH_W) ? (EXP_W + 1) : SH_W;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_v1;
    logic r_v2;
    logic w_adv1;
    logic w_adv2;

    assign w_adv2    = !r_v2 || out_ready;
    assign w_adv1    = !r_v1 || w_adv2;
    assign in_ready  = w_adv1;
    assign out_valid = r_v2;

    // ------------------------------------------------------------------
    // Stage 1: leading-zero count
    // ------------------------------------------------------------------
    logic [SH_W-1:0] w_lzc;

    // Scan upward so the highest set bit is the last writer; all-zero keeps MANT_W.
    always_comb begin
        w_lzc = SH_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (in_mant[i]) begin
                w_lzc = SH_W'(MANT_W - 1 - i);
            end
        end
    end

    logic [MANT_W-1:0] r_s1_mant;
    logic [EXP_W-1:0]  r_s1_exp;
    logic [SH_W-1:0]   r_s1_lzc;
    logic              r_s1_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1      <= 1'b0;
            r_s1_mant <= '0;
            r_s1_exp  <= '0;
            r_s1_lzc  <= '0;
            r_s1_zero <= 1'b0;
        end else if (w_adv1) begin
            r_v1 <= in_valid;
            // Data only moves on a real accept; idle cycles leave the registers quiet.
            if (in_valid) begin
                r_s1_mant <= in_mant;
                r_s1_exp  <= in_exp;
                r_s1_lzc  <= w_lzc;
                r_s1_zero <= (in_mant == '0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: shift and exponent adjust
    // ------------------------------------------------------------------
    logic [CW-1:0]     w_exp_c;
    logic [CW-1:0]     w_lzc_c;
    logic [CW-1:0]     w_sub;
    logic              w_norm_ok;
    logic [SH_W-1:0]   w_uf_shift;

    assign w_exp_c = CW'(r_s1_exp);
    assign w_lzc_c = CW'(r_s1_lzc);
    // Widened subtraction cannot wrap: a set MSB is a borrow, i.e. exp < lzc.
    assign w_sub     = w_exp_c - w_lzc_c;
    assign w_norm_ok = !w_sub[CW-1] && (w_sub != '0);

    // On underflow exp <= lzc <= MANT_W, so exp fits in SH_W bits. Shifting by exp-1
    // leaves the exponent at the subnormal encoding 0 (implicit weight of exponent 1).
    assign w_uf_shift = (r_s1_exp == '0) ? '0 : (SH_W'(r_s1_exp) - SH_W'(1));

    logic [MANT_W-1:0] w_nx_mant;
    logic [EXP_W-1:0]  w_nx_exp;
    logic [SH_W-1:0]   w_nx_shift;
    logic              w_nx_zero;
    logic              w_nx_denorm;

    always_comb begin
        w_nx_mant   = '0;
        w_nx_exp    = '0;
        w_nx_shift  = '0;
        w_nx_zero   = 1'b0;
        w_nx_denorm = 1'b0;
        if (r_s1_zero) begin
            w_nx_zero = 1'b1;
        end else if (w_norm_ok) begin
            w_nx_shift = r_s1_lzc;
            w_nx_mant  = r_s1_mant << r_s1_lzc;
            w_nx_exp   = w_sub[EXP_W-1:0];
        end else begin
`ifdef FP_NORM_FLUSH_EN
            // Denorm flag survives the flush so rounding can still raise underflow.
            w_nx_zero   = 1'b1;
            w_nx_denorm = 1'b1;
`else
            w_nx_shift  = w_uf_shift;
            w_nx_mant   = r_s1_mant << w_uf_shift;
            w_nx_denorm = 1'b1;
`endif
        end
    end

    logic [MANT_W-1:0] r_out_mant;
    logic [EXP_W-1:0]  r_out_exp;
    logic [SH_W-1:0]   r_out_shift;
    logic              r_out_zero;
    logic              r_out_denorm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2         <= 1'b0;
            r_out_mant   <= '0;
            r_out_exp    <= '0;
            r_out_shift  <= '0;
            r_out_zero   <= 1'b0;
            r_out_denorm <= 1'b0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_out_mant   <= w_nx_mant;
                r_out_exp    <= w_nx_exp;
                r_out_shift  <= w_nx_shift;
                r_out_zero   <= w_nx_zero;
                r_out_denorm <= w_nx_denorm;
            end
        end
    end

    assign out_mant   = r_out_mant;
    assign out_exp    = r_out_exp;
    assign out_shift  = r_out_shift;
    assign out_zero   = r_out_zero;
    assign out_denorm = r_out_denorm;

endmodule

// File: doc/fp_norm_pipe.md
Name: fp_norm_pipe

Overview:
- Parametrised, pipelined successor to the combinational leading-one normaliser in the floating-point multiplier datapath.
- Per transaction: accepts an unnormalised mantissa and a biased exponent, counts leading zeros, left-shifts the mantissa so its MSB is 1, and decrements the exponent by the shift amount.
- Adds exponent-underflow (subnormal) handling, zero detection and a valid/ready handshake.
- Sits between the mantissa multiplier/adder and the rounding stage.

Parameters:
- MANT_W, 24, mantissa width in bits (>= 4).
- EXP_W, 8, biased exponent width in bits (>= 3).
- SH_W, $clog2(MANT_W+1), width of the shift-count output (localparam, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept an input this cycle.
- in_mant  in  MANT_W  unnormalised mantissa.
- in_exp  in  EXP_W  biased exponent, unsigned.
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream accepts the output.
- out_mant  out  MANT_W  normalised mantissa.
- out_exp  out  EXP_W  adjusted biased exponent.
- out_shift  out  SH_W  left-shift amount actually applied.
- out_zero  out  1  input mantissa was zero.
- out_denorm  out  1  result is subnormal (exponent clamped to 0).

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is asynchronous assert, synchronous deassert by the system.
  - On reset, both stage valid flags, and all data/flag output registers, clear to 0. in_ready therefore reads 1 after reset.
- Pipeline: two register stages. Latency is exactly 2 cycles from accept (in_valid & in_ready) to out_valid when out_ready is held 1.
- Stage 1 (S1) registers:
  - mant and exp.
  - lzc: the leading-zero count, 0..MANT_W, from a priority encoder over MANT_W bits.
  - zero flag: (mant == 0).
- Stage 2 (S2) computes from the S1 registers and registers all outputs:
  - zero: out_mant=0, out_exp=0, out_shift=0, out_zero=1, out_denorm=0.
  - else if in_exp > lzc: shift=lzc, out_mant=mant<<lzc (MSB=1), out_exp=in_exp-lzc, out_denorm=0.
  - else (underflow, including in_exp=0): shift = (in_exp==0) ? 0 : in_exp-1, out_mant=mant<<shift, out_exp=0, out_denorm=1.
  - Exponent subtraction is done at EXP_W+1 bits; it never wraps.
- Handshake (full-throughput, no bubbles):
  - adv2 = !v2 | out_ready
  - adv1 = !v1 | adv2
  - in_ready = adv1
  - S1 loads when adv1, with v1 <= in_valid.
  - S2 loads when adv2, with v2 <= v1.
  - out_valid = v2.
- Stall rule: while out_ready=0 and v2=1, the output registers hold stable.
- Capacity: at most two transactions in flight; after that in_ready=0 until out_ready rises.
- Simultaneous accept at input and output in the same cycle is legal; throughput is 1 per cycle.
- Data is never dropped or reordered.
- in_mant/in_exp are sampled only on accept; they are don't-care otherwise.
- Reset mid-stream: in-flight transactions are discarded; out_valid drops immediately (asynchronous).

Optional Feature:
- Macro: FP_NORM_FLUSH_EN.
- Defined: any underflow result is flushed. out_mant=0, out_exp=0, out_shift=0, out_zero=1, out_denorm=1 (flag retained so rounding logic can raise underflow).
- Undefined: subnormal results are produced as described in Behaviour.
- Latency and handshake are identical in both builds.

Test Plan (MANT_W=24, EXP_W=8):
- in_mant=0x800000, in_exp=0x80 -> out_mant=0x800000, out_exp=0x80, out_shift=0, flags 0; out_valid exactly 2 cycles after accept.
- in_mant=0x000001, in_exp=0x80 -> out_shift=23, out_mant=0x800000, out_exp=0x69.
- in_mant=0x000000, in_exp=0x55 -> out_zero=1, out_mant=0, out_exp=0, out_shift=0.
- in_mant=0x001000 (lzc=11), in_exp=0x05 -> out_shift=4, out_mant=0x010000, out_exp=0, out_denorm=1. With FP_NORM_FLUSH_EN: out_mant=0, out_zero=1, out_denorm=1.
- Stream of 6 back-to-back inputs, out_ready=0 for cycles 3-5 -> in_ready falls after 2 in flight; all 6 outputs are delivered in order with correct values; out_data is stable while stalled.
- rst_n pulsed low with 2 transactions in flight -> out_valid=0 asynchronously; after release in_ready=1 and no stale output appears.
